status_flag_unit: RTL and testbench

Generates the N, Z, C and V flags from execute-stage operands and holds them in the processor status register that feeds condition evaluation in decode. The block also provides a direct flag-write port (MSR-style) and a one-deep saved copy for exception entry and return. It sits at the end of the execute stage. Its `status_register` output uses the packing the condition checker expects: Z at bit 3, C at bit 2, N at bit 1, V at bit 0.

---
 rtl/status_flag_unit_if.sv | 37 +++
 rtl/status_flag_unit.sv | 67 ++++++
 tb/tb_status_flag_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/status_flag_unit_if.sv
// Execute-stage flag update bus: ALU/MSR/exception controls in, status flags out.
// Flags are packed {Z,C,N,V} throughout.
interface status_flag_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             flush;
    logic             upd_valid;
    logic             upd_s;
    logic             upd_cond_pass;
    logic [2:0]       flag_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] logic_result;
    logic             shifter_carry;
    logic             msr_we;
    logic [3:0]       msr_flags;
    logic             exc_save;
    logic             exc_restore;
    logic [3:0]       status_register;
    logic [3:0]       status_next;
    logic [3:0]       saved_status;

    modport master (
        output stall, flush, upd_valid, upd_s, upd_cond_pass, flag_op,
               op_a, op_b, logic_result, shifter_carry,
               msr_we, msr_flags, exc_save, exc_restore,
        input  status_register, status_next, saved_status
    );

    modport slave (
        input  stall, flush, upd_valid, upd_s, upd_cond_pass, flag_op,
               op_a, op_b, logic_result, shifter_carry,
               msr_we, msr_flags, exc_save, exc_restore,
        output status_register, status_next, saved_status
    );
endinterface

// File: rtl/status_flag_unit.sv
// NZCV flag generation and live/saved status registers at the end of execute.
// status_next exposes the next-edge value so decode can bypass without a cycle of delay.
module status_flag_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    status_flag_unit_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    logic [3:0]       status_q, status_d;
    logic [3:0]       saved_q, saved_d;
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             fire;
    logic [3:0]       alu_flags;

    assign fire = bus.upd_valid & bus.upd_s & bus.upd_cond_pass & ~bus.stall
                & ~bus.flush & (bus.flag_op <= 3'b100);

    // Subtracts are a + ~b + cin so C reads as "no borrow".
    always_comb begin
        b_eff = bus.op_b;
        cin   = 1'b0;
        case (bus.flag_op)
            3'b010: cin = status_q[2];
            3'b011: begin b_eff = ~bus.op_b; cin = 1'b1;        end
            3'b100: begin b_eff = ~bus.op_b; cin = status_q[2]; end
            default: ;
        endcase
        sum = {1'b0, bus.op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        if (bus.flag_op == 3'b000) begin
            alu_flags = {(bus.logic_result == '0), bus.shifter_carry,
                         bus.logic_result[MSB], status_q[0]};
        end else begin
            alu_flags = {(sum[MSB:0] == '0), sum[WIDTH], sum[MSB],
                         (bus.op_a[MSB] == b_eff[MSB]) & (sum[MSB] != bus.op_a[MSB])};
        end
    end

    always_comb begin
        status_d = status_q;
        if (bus.exc_restore)               status_d = saved_q;
        else if (bus.msr_we && !bus.stall) status_d = bus.msr_flags;
        else if (fire)                     status_d = alu_flags;
        saved_d = bus.exc_save ? status_q : saved_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= 4'b0000;
            saved_q  <= 4'b0000;
        end else begin
            status_q <= status_d;
            saved_q  <= saved_d;
        end
    end

    assign bus.status_register = status_q;
    assign bus.status_next     = status_d;
    assign bus.saved_status    = saved_q;
endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: expected flags queued at drive time, popped after the edge.
module tb_status_flag_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [3:0] exp_q[$];

    status_flag_unit_if #(.WIDTH(32)) sif ();
    status_flag_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(sif));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic clr();
        sif.stall = 0; sif.flush = 0; sif.upd_valid = 0; sif.upd_s = 0;
        sif.upd_cond_pass = 0; sif.flag_op = 3'b000; sif.op_a = '0; sif.op_b = '0;
        sif.logic_result = '0; sif.shifter_carry = 0; sif.msr_we = 0;
        sif.msr_flags = 4'b0000; sif.exc_save = 0; sif.exc_restore = 0;
    endtask

    task automatic alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lr, input logic sc);
        sif.upd_valid = 1; sif.upd_s = 1; sif.upd_cond_pass = 1;
        sif.flag_op = op; sif.op_a = a; sif.op_b = b; sif.logic_result = lr;
        sif.shifter_carry = sc;
    endtask

    task automatic msr(input logic [3:0] f);
        sif.msr_we = 1; sif.msr_flags = f;
    endtask

    // Check bypass now, queue the registered expectation, then compare after the edge.
    task automatic step(input string tag, input logic [3:0] exp);
        logic [3:0] e;
        #1 chk({tag, "_next"}, sif.status_next, exp);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_reg"}, sif.status_register, e);
    endtask

    initial begin
        clr();
        #2;
        chk("rst_reg", sif.status_register, 4'b0000);
        chk("rst_saved", sif.saved_status, 4'b0000);
        chk("rst_next", sif.status_next, 4'b0000);
        @(negedge clk); rst_n = 1;

        @(negedge clk); clr(); alu(3'b001, 32'h7FFF_FFFF, 32'h1, '0, 0);
        step("add_ovf", 4'b0011);
        @(negedge clk); clr(); alu(3'b011, 32'd5, 32'd5, '0, 0);
        step("sub_eq", 4'b1100);
        @(negedge clk); clr(); alu(3'b100, 32'd0, 32'd0, '0, 0);
        step("sbc_00", 4'b1100);
        @(negedge clk); clr(); alu(3'b100, 32'd0, 32'd1, '0, 0);
        step("sbc_01", 4'b0010);

        @(negedge clk); clr(); msr(4'b0001);
        step("msr_0001", 4'b0001);
        @(negedge clk); clr(); alu(3'b000, 32'd7, 32'd9, 32'd0, 1);
        step("logic_z", 4'b1101);
        @(negedge clk); clr(); msr(4'b0001);
        step("msr_0001b", 4'b0001);
        @(negedge clk); clr(); alu(3'b000, 32'd7, 32'd9, 32'd0, 1); sif.upd_cond_pass = 0;
        step("cond_fail", 4'b0001);
        @(negedge clk); clr(); alu(3'b000, 32'd7, 32'd9, 32'd0, 1); sif.upd_s = 0;
        step("no_s", 4'b0001);
        @(negedge clk); clr(); alu(3'b101, 32'd0, 32'd0, 32'd0, 1);
        step("rsvd_op", 4'b0001);
        @(negedge clk); clr(); alu(3'b001, 32'd0, 32'd0, 32'd0, 1); sif.flush = 1;
        step("flush", 4'b0001);

        @(negedge clk); clr(); msr(4'b0100);
        step("msr_c", 4'b0100);
        @(negedge clk); clr(); alu(3'b010, 32'hFFFF_FFFF, 32'd0, '0, 0);
        step("adc_wrap", 4'b1100);
        @(negedge clk); clr(); msr(4'b0100);
        step("msr_c2", 4'b0100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); clr(); alu(3'b010, 32'hFFFF_FFFF, 32'd0, '0, 0); sif.stall = 1;
            msr(4'b1111);
            step("stall_hold", 4'b0100);
        end
        @(negedge clk); clr(); alu(3'b010, 32'hFFFF_FFFF, 32'd0, '0, 0);
        step("stall_release", 4'b1100);

        @(negedge clk); clr(); msr(4'b1010);
        step("msr_1010", 4'b1010);
        @(negedge clk); clr(); msr(4'b0101); sif.exc_save = 1;
        step("save_msr", 4'b0101);
        chk("save_msr_saved", sif.saved_status, 4'b1010);
        @(negedge clk); clr(); sif.exc_save = 1; sif.exc_restore = 1; sif.stall = 1;
        step("swap", 4'b1010);
        chk("swap_saved", sif.saved_status, 4'b0101);
        @(negedge clk); clr(); sif.exc_save = 1; alu(3'b001, 32'h7FFF_FFFF, 32'h1, '0, 0);
        step("save_fire", 4'b0011);
        chk("save_fire_saved", sif.saved_status, 4'b1010);

        @(negedge clk); clr(); msr(4'b1111); alu(3'b011, 32'd5, 32'd5, '0, 0);
        step("msr_vs_fire", 4'b1111);

        @(negedge clk); clr(); #2 rst_n = 0; #1;
        chk("async_rst_reg", sif.status_register, 4'b0000);
        chk("async_rst_saved", sif.saved_status, 4'b0000);
        chk("async_rst_next", sif.status_next, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
